// File: rtl/f_pc_sequencer.sv
// Fetch-stage PC sequencer: owns the F-stage PC, issues imem req/ready fetches, applies
// delayed-branch redirects and buffers a fetched word under stall. Option: PC_ALIGN_CHECK_EN.
module f_pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
`ifdef PC_ALIGN_CHECK_EN
  ,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redir_valid,
  input  logic [31:0] redir_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        f_valid,
  output logic [31:0] f_instr,
  output logic [31:0] f_pc
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic        align_exc
`endif
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  localparam logic ST_REQ  = 1'b0;
  localparam logic ST_HOLD = 1'b1;

  logic          state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          pend_valid_q, pend_valid_d;
  logic [AW-1:0] pend_target_q, pend_target_d;
  logic [DW-1:0] buf_q, buf_d;
  logic [AW-1:0] buf_pc_q, buf_pc_d;
  logic          f_valid_q, f_valid_d;
  logic [DW-1:0] f_instr_q, f_instr_d;
  logic [AW-1:0] f_pc_q, f_pc_d;

  logic          accept;
  logic          fetch_done;
  logic [AW-1:0] tgt_eff;

  // Redirect target after alignment handling
`ifdef PC_ALIGN_CHECK_EN
  logic          misaligned;
  logic          align_exc_q, align_exc_d;

  assign misaligned = (redir_target[1:0] != 2'b00);
  assign tgt_eff    = misaligned ? EXC_PC : redir_target;
  assign align_exc  = align_exc_q;
`else
  assign tgt_eff    = redir_target & ~AW'(3);
`endif

  assign accept     = ~stall & redir_valid;
  assign fetch_done = (state_q == ST_REQ) & imem_ready;

  // Request is combinational on reset so it drops the moment reset asserts
  assign imem_req  = reset & (state_q == ST_REQ);
  assign imem_addr = pc_q;
  assign f_valid   = f_valid_q;
  assign f_instr   = f_instr_q;
  assign f_pc      = f_pc_q;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_REQ;
      pc_q          <= RESET_PC;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      buf_q         <= '0;
      buf_pc_q      <= '0;
      f_valid_q     <= 1'b0;
      f_instr_q     <= '0;
      f_pc_q        <= RESET_PC;
`ifdef PC_ALIGN_CHECK_EN
      align_exc_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      buf_q         <= buf_d;
      buf_pc_q      <= buf_pc_d;
      f_valid_q     <= f_valid_d;
      f_instr_q     <= f_instr_d;
      f_pc_q        <= f_pc_d;
`ifdef PC_ALIGN_CHECK_EN
      align_exc_q   <= align_exc_d;
`endif
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    buf_d         = buf_q;
    buf_pc_d      = buf_pc_q;
    f_valid_d     = f_valid_q;
    f_instr_d     = f_instr_q;
    f_pc_d        = f_pc_q;
`ifdef PC_ALIGN_CHECK_EN
    align_exc_d   = accept & misaligned;
`endif

    if (state_q == ST_REQ) begin
      if (fetch_done) begin
        // Delay slot just completed: a fresh redirect beats a pending one
        pend_valid_d = 1'b0;
        if (accept) begin
          pc_d = tgt_eff;
        end else if (pend_valid_q) begin
          pc_d = pend_target_q;
        end else begin
          pc_d = pc_q + AW'(4);
        end
        if (!stall) begin
          f_valid_d = 1'b1;
          f_instr_d = imem_rdata;
          f_pc_d    = pc_q;
        end else begin
          buf_d    = imem_rdata;
          buf_pc_d = pc_q;
          state_d  = ST_HOLD;
        end
      end else begin
        if (accept) begin
          pend_valid_d  = 1'b1;
          pend_target_d = tgt_eff;
        end
        if (!stall) begin
          f_valid_d = 1'b0;
        end
      end
    end else begin
      // pc already points past the delay slot, so a redirect here applies directly
      if (!stall) begin
        f_valid_d = 1'b1;
        f_instr_d = buf_q;
        f_pc_d    = buf_pc_q;
        state_d   = ST_REQ;
        if (accept) begin
          pc_d = tgt_eff;
        end
      end
    end
  end

endmodule

// File: tb/tb_f_pc_sequencer.sv
// Bench for f_pc_sequencer: directed scenarios plus random stimulus against a queue-based
// model of the fetch stream. Honours PC_ALIGN_CHECK_EN when defined.
module tb_f_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] EXC    = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redir_valid;
  logic [31:0] redir_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        f_valid;
  logic [31:0] f_instr;
  logic [31:0] f_pc;
`ifdef PC_ALIGN_CHECK_EN
  logic        align_exc;
`endif

  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  always #5 clk = ~clk;

  f_pc_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .redir_valid  (redir_valid),
    .redir_target (redir_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .f_valid      (f_valid),
    .f_instr      (f_instr),
    .f_pc         (f_pc)
`ifdef PC_ALIGN_CHECK_EN
    ,
    .align_exc    (align_exc)
`endif
  );

  // Model: fetch PC, delivered F/D payload, pending redirect and a queue of stalled words
  logic [31:0] m_pc, m_fi, m_fpc, m_pt;
  logic        m_fv, m_pend, m_exc;
  logic [63:0] hq[$];

  function automatic logic m_req();
    return reset && (hq.size() == 0);
  endfunction

  task automatic model_reset();
    m_pc = RST_PC; m_fi = '0; m_fpc = RST_PC; m_fv = 1'b0;
    m_pend = 1'b0; m_pt = '0; m_exc = 1'b0;
    hq.delete();
  endtask

  task automatic model_step();
    logic        acc, mis;
    logic [31:0] tgt, nxt, w;
    if (!reset) return;
    acc = !stall && redir_valid;
    mis = (redir_target[1:0] != 2'b00);
`ifdef PC_ALIGN_CHECK_EN
    tgt   = mis ? EXC : redir_target;
    m_exc = acc && mis;
`else
    tgt   = {redir_target[31:2], 2'b00};
`endif
    if (hq.size() != 0) begin
      if (!stall) begin
        {m_fpc, m_fi} = hq.pop_front();
        m_fv = 1'b1;
        if (acc) m_pc = tgt;
      end
    end else if (imem_ready) begin
      w   = mem_word(m_pc);
      nxt = acc ? tgt : (m_pend ? m_pt : m_pc + 32'd4);
      m_pend = 1'b0;
      if (!stall) begin
        m_fv = 1'b1; m_fi = w; m_fpc = m_pc;
      end else begin
        hq.push_back({m_pc, w});
      end
      m_pc = nxt;
    end else begin
      if (acc) begin m_pend = 1'b1; m_pt = tgt; end
      if (!stall) m_fv = 1'b0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; stall = 1'b0; redir_valid = 1'b0; redir_target = '0; imem_ready = 1'b1;
    model_reset();
    #1;
    tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; redir_valid = 1'b0; redir_target = '0; imem_ready = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
    tick(); tick();
    total++;
    if ({imem_req, imem_addr, f_valid, f_instr, f_pc} !== {1'b0, RST_PC, 1'b0, 32'h0, RST_PC}) begin
      bad++;
      $display("FAIL reset_vals got req=%b addr=%h fv=%b fi=%h fpc=%h", imem_req, imem_addr, f_valid, f_instr, f_pc);
    end
    reset = 1'b1;
    #1;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
      bad++;
      $display("FAIL reset_release got req=%b addr=%h want 1/%h", imem_req, imem_addr, RST_PC);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      tick();
      total++;
      if (imem_addr !== RST_PC + 32'(4 * i) || f_valid !== 1'b1 || f_pc !== RST_PC + 32'(4 * (i - 1))
          || f_instr !== mem_word(RST_PC + 32'(4 * (i - 1)))) begin
        bad++;
        $display("FAIL seq_%0d got addr=%h fv=%b fpc=%h fi=%h", i, imem_addr, f_valid, f_pc, f_instr);
      end
    end
  endtask

  task automatic test_stall_hold();
    do_reset();
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (imem_req !== 1'b0 || f_pc !== RST_PC || f_valid !== 1'b1) begin
        bad++;
        $display("FAIL hold_%0d got req=%b fpc=%h fv=%b want 0/%h/1", i, imem_req, f_pc, f_valid, RST_PC);
      end
    end
    stall = 1'b0;
    tick();
    total++;
    if (f_pc !== 32'h3004 || f_instr !== mem_word(32'h3004) || imem_addr !== 32'h3008 || imem_req !== 1'b1) begin
      bad++;
      $display("FAIL hold_release got fpc=%h fi=%h addr=%h req=%b", f_pc, f_instr, imem_addr, imem_req);
    end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    tick(); tick();
    imem_ready = 1'b0; redir_valid = 1'b1; redir_target = 32'h3100;
    tick();
    redir_valid = 1'b0;
    tick();
    total++;
    if (imem_addr !== 32'h3008 || f_valid !== 1'b0) begin
      bad++;
      $display("FAIL redir_wait got addr=%h fv=%b want 3008/0", imem_addr, f_valid);
    end
    imem_ready = 1'b1;
    tick();
    total++;
    if (f_pc !== 32'h3008 || f_valid !== 1'b1 || imem_addr !== 32'h3100) begin
      bad++;
      $display("FAIL redir_slot got fpc=%h fv=%b addr=%h want 3008/1/3100", f_pc, f_valid, imem_addr);
    end
    tick();
    total++;
    if (imem_addr !== 32'h3104 || f_pc !== 32'h3100) begin
      bad++;
      $display("FAIL redir_after got addr=%h fpc=%h want 3104/3100", imem_addr, f_pc);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    tick();
    imem_ready = 1'b0;
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    total++;
    if ({imem_req, imem_addr, f_valid, f_instr, f_pc} !== {1'b0, RST_PC, 1'b0, 32'h0, RST_PC}) begin
      bad++;
      $display("FAIL midreset got req=%b addr=%h fv=%b fi=%h fpc=%h", imem_req, imem_addr, f_valid, f_instr, f_pc);
    end
    tick();
    reset = 1'b1; imem_ready = 1'b1;
    #1;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
      bad++;
      $display("FAIL midreset_release got req=%b addr=%h", imem_req, imem_addr);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    redir_valid = 1'b1; redir_target = 32'hFFFF_FFFC;
    tick();
    redir_valid = 1'b0;
    total++;
    if (imem_addr !== 32'hFFFF_FFFC) begin
      bad++;
      $display("FAIL wrap_target got addr=%h want fffffffc", imem_addr);
    end
    tick();
    total++;
    if (imem_addr !== 32'h0 || f_pc !== 32'hFFFF_FFFC) begin
      bad++;
      $display("FAIL wrap got addr=%h fpc=%h want 0/fffffffc", imem_addr, f_pc);
    end
  endtask

  task automatic test_align();
    logic [31:0] want;
`ifdef PC_ALIGN_CHECK_EN
    want = EXC;
`else
    want = 32'h3100;
`endif
    do_reset();
    redir_valid = 1'b1; redir_target = 32'h3102;
    tick();
    redir_valid = 1'b0;
    total++;
    if (imem_addr !== want) begin
      bad++;
      $display("FAIL align_addr got %h want %h", imem_addr, want);
    end
`ifdef PC_ALIGN_CHECK_EN
    total++;
    if (align_exc !== 1'b1) begin
      bad++;
      $display("FAIL align_pulse got %b want 1", align_exc);
    end
`endif
    tick();
`ifdef PC_ALIGN_CHECK_EN
    total++;
    if (align_exc !== 1'b0) begin
      bad++;
      $display("FAIL align_clear got %b want 0", align_exc);
    end
`endif
    total++;
    if (f_pc !== want) begin
      bad++;
      $display("FAIL align_fpc got %h want %h", f_pc, want);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      stall        = ($urandom_range(3) == 0);
      imem_ready   = ($urandom_range(2) != 0);
      redir_valid  = ($urandom_range(5) == 0);
      redir_target = 32'h0000_3000 + ($urandom & 32'h0000_0FFF);
      if ($urandom_range(199) == 0) begin
        reset = 1'b0;
        model_reset();
        #1;
      end
      tick();
      reset = 1'b1;
      #1;
      total++;
      if ({imem_req, imem_addr, f_valid, f_instr, f_pc} !== {m_req(), m_pc, m_fv, m_fi, m_fpc}) begin
        bad++;
        $display("FAIL rand_%0d got req=%b addr=%h fv=%b fi=%h fpc=%h want %b %h %b %h %h", i,
                 imem_req, imem_addr, f_valid, f_instr, f_pc, m_req(), m_pc, m_fv, m_fi, m_fpc);
      end
`ifdef PC_ALIGN_CHECK_EN
      total++;
      if (align_exc !== m_exc) begin
        bad++;
        $display("FAIL rand_exc_%0d got %b want %b", i, align_exc, m_exc);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall_hold();
    test_redirect_wait();
    test_reset_midflight();
    test_wrap();
    test_align();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/f_pc_sequencer.md
Name: f_pc_sequencer

Overview:
- Fetch-stage controller. Owns the F-stage PC register and sequences instruction-memory reads through a req/ready handshake.
- Applies D-stage redirects (taken beq, jal, jr) after the delay-slot fetch, and holds or buffers fetched words under hazard stall.
- Delivers f_valid/f_instr/f_pc to the F/D pipeline register. Sits between the D-stage next-PC logic and the instruction memory.

Parameters:
- RESET_PC, 32'h0000_3000, PC loaded on reset.
- EXC_PC, 32'h0000_4180, handler PC used only by the optional alignment check.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hazard-unit stall for F/D; 1 = F/D register must hold.
- redir_valid  in  1  D-stage redirect request; sampled only when stall=0.
- redir_target  in  32  redirect target PC.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; equals the PC register.
- imem_ready  in  1  memory response; data valid on imem_rdata in the same cycle.
- imem_rdata  in  32  fetched word.
- f_valid  out  1  F/D payload valid (0 = bubble).
- f_instr  out  32  fetched instruction.
- f_pc  out  32  PC of f_instr.
- align_exc  out  1  alignment exception pulse; port present only with PC_ALIGN_CHECK_EN.

Behaviour:
- Reset (reset=0, async) values: pc=RESET_PC; state=REQ; f_valid=0; f_instr=0; f_pc=RESET_PC; pend_valid=0; buffer cleared; align_exc=0. imem_req is held 0 while reset=0.
- An in-flight response is discarded when reset asserts mid-transaction. After release, the first request is to RESET_PC.
- FSM states: REQ, HOLD.
- REQ:
  - imem_req=1 and imem_addr=pc, held stable until an edge where imem_ready=1 ("fetch completes").
  - Completion with stall=0: f_valid<=1, f_instr<=imem_rdata, f_pc<=pc, pc<=next_pc. State stays REQ, so a zero-wait memory yields 1 instruction per cycle.
  - Completion with stall=1: F/D outputs hold; buf<=imem_rdata, buf_pc<=pc; pc<=next_pc; go to HOLD.
  - No completion, stall=0: f_valid<=0 (bubble); f_instr and f_pc hold.
  - No completion, stall=1: all outputs hold.
- HOLD:
  - imem_req=0.
  - While stall=1, hold.
  - On stall=0: f_valid<=1, f_instr<=buf, f_pc<=buf_pc; go to REQ.
- next_pc rules:
  - pc+4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
  - Redirect accepted at an edge with stall=0 and redir_valid=1. The instruction currently being fetched is the delay slot and is never squashed.
  - Accepted on the same edge as a completion: pc<=redir_target.
  - Otherwise: pend_target<=redir_target, pend_valid<=1. The next completion loads pc<=pend_target and clears pend_valid.
  - A new redirect while pend_valid=1 overwrites pend_target (newer wins).
  - Redirect accepted in HOLD: pc is already the post-slot fetch address, so pc<=redir_target directly and pend_valid stays 0.
- Latency: redirect accepted at edge N with a zero-wait memory gives imem_addr=target in cycle N+1.

Optional Feature:
- Macro PC_ALIGN_CHECK_EN.
- Defined:
  - A redirect with redir_target[1:0]!=2'b00 loads EXC_PC instead of the target, via the same immediate or pending path.
  - align_exc pulses 1 for one cycle after the accepting edge.
- Undefined:
  - redir_target[1:0] is forced to 2'b00.
  - No align_exc port and no EXC_PC use.

Test Plan:
- Reset release, imem_ready tied 1, stall=0 → imem_addr 0x3000, 0x3004, 0x3008 on consecutive cycles; f_valid=1 from the 2nd cycle; f_pc lags imem_addr by 1.
- Fetch at 0x3004 completes with stall=1 for 3 cycles → f_pc holds 0x3000 and imem_req=0 during HOLD. On stall=0, f_pc=0x3004 with the buffered word, then fetching resumes at 0x3008.
- redir_valid=1, target 0x3100, while 0x3008 is being fetched with 2 wait cycles → 0x3008 (delay slot) still delivered; next imem_addr=0x3100; pend_valid clears.
- Assert reset for 1 cycle while imem_req=1 and imem_ready=0 → all outputs return to reset values at once; first post-reset address is 0x3000.
- pc=0xFFFF_FFFC, zero-wait → next imem_addr=0x0000_0000.
- With PC_ALIGN_CHECK_EN: redirect to 0x3102 → align_exc=1 for 1 cycle; next fetch from 0x4180. Without the macro: the same redirect fetches 0x3100.
